// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: word widths, pipeline latency, credit limit and the
// in-flight tag that follows each operation through the pipeline.
package cordic_pkg;

    localparam int DATA_WIDTH      = 16;
    localparam int FLIP_FLAG_WIDTH = 2;
    localparam int PIPE_LATENCY    = 8;
    localparam int MAX_OUTSTANDING = 4;
    localparam int CNT_WIDTH       = 4;

    typedef struct packed {
        logic valid;
        logic id;
    } cordic_tag_t;

endpackage

// File: rtl/cordic_arbiter_if.sv
// Requester, response and pipeline-facing signals of the CORDIC arbiter.
// The slave view belongs to the arbiter; the master view to requesters and pipeline.
interface cordic_arbiter_if #(
    parameter int DATA_WIDTH      = cordic_pkg::DATA_WIDTH,
    parameter int FLIP_FLAG_WIDTH = cordic_pkg::FLIP_FLAG_WIDTH
);

    logic                       r0_valid;
    logic                       r0_ready;
    logic [DATA_WIDTH-1:0]      r0_degree;
    logic [DATA_WIDTH-1:0]      r0_x;
    logic [DATA_WIDTH-1:0]      r0_y;
    logic [FLIP_FLAG_WIDTH-1:0] r0_flip;
    logic                       r0_arctan_en;
    logic                       r0_rsp_valid;

    logic                       r1_valid;
    logic                       r1_ready;
    logic [DATA_WIDTH-1:0]      r1_degree;
    logic [DATA_WIDTH-1:0]      r1_x;
    logic [DATA_WIDTH-1:0]      r1_y;
    logic [FLIP_FLAG_WIDTH-1:0] r1_flip;
    logic                       r1_arctan_en;
    logic                       r1_rsp_valid;

    logic [DATA_WIDTH-1:0]      rsp_degree;
    logic [DATA_WIDTH-1:0]      rsp_x;
    logic [DATA_WIDTH-1:0]      rsp_y;
    logic [FLIP_FLAG_WIDTH-1:0] rsp_flip;
    logic                       rsp_arctan_en;

    logic                       cdc_valid_in;
    logic [DATA_WIDTH-1:0]      cdc_degree_in;
    logic [DATA_WIDTH-1:0]      cdc_x_in;
    logic [DATA_WIDTH-1:0]      cdc_y_in;
    logic [FLIP_FLAG_WIDTH-1:0] cdc_flip_in;
    logic                       cdc_arctan_en_in;

    logic                       cdc_valid_out;
    logic [DATA_WIDTH-1:0]      cdc_degree_out;
    logic [DATA_WIDTH-1:0]      cdc_x_out;
    logic [DATA_WIDTH-1:0]      cdc_y_out;
    logic [FLIP_FLAG_WIDTH-1:0] cdc_flip_out;
    logic                       cdc_arctan_en_out;

    logic                       err;

    modport slave (
        input  r0_valid, r0_degree, r0_x, r0_y, r0_flip, r0_arctan_en,
        input  r1_valid, r1_degree, r1_x, r1_y, r1_flip, r1_arctan_en,
        output r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid,
        output rsp_degree, rsp_x, rsp_y, rsp_flip, rsp_arctan_en,
        output cdc_valid_in, cdc_degree_in, cdc_x_in, cdc_y_in, cdc_flip_in, cdc_arctan_en_in,
        input  cdc_valid_out, cdc_degree_out, cdc_x_out, cdc_y_out, cdc_flip_out, cdc_arctan_en_out,
        output err
    );

    modport master (
        output r0_valid, r0_degree, r0_x, r0_y, r0_flip, r0_arctan_en,
        output r1_valid, r1_degree, r1_x, r1_y, r1_flip, r1_arctan_en,
        input  r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid,
        input  rsp_degree, rsp_x, rsp_y, rsp_flip, rsp_arctan_en,
        input  cdc_valid_in, cdc_degree_in, cdc_x_in, cdc_y_in, cdc_flip_in, cdc_arctan_en_in,
        output cdc_valid_out, cdc_degree_out, cdc_x_out, cdc_y_out, cdc_flip_out, cdc_arctan_en_out,
        input  err
    );

endinterface

// File: rtl/cordic_tag_line.sv
// Fixed-length shift line of (valid, requester id) tags that rides alongside the
// CORDIC pipeline so each result can be routed back to its requester.
module cordic_tag_line
    import cordic_pkg::*;
#(
    parameter int DEPTH = PIPE_LATENCY + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  cordic_tag_t tag_in,
    output cordic_tag_t tag_out
);

    cordic_tag_t line_q [DEPTH];

    // NOTE: every entry is reset, not just the head: a stale valid tag left in the
    // line would route a phantom result to a requester after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage read its
            // neighbour's old value, so the line shifts by exactly one per clock.
            line_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    assign tag_out = line_q[DEPTH-1];

endmodule

// File: rtl/cordic_arbiter.sv
// Two-requester round-robin front end for a fixed-latency CORDIC pipeline with
// per-requester credit limits, tag-routed registered responses and a sticky error.
module cordic_arbiter
    import cordic_pkg::cordic_tag_t;
#(
    parameter int DATA_WIDTH      = cordic_pkg::DATA_WIDTH,
    parameter int FLIP_FLAG_WIDTH = cordic_pkg::FLIP_FLAG_WIDTH,
    parameter int PIPE_LATENCY    = cordic_pkg::PIPE_LATENCY,
    parameter int MAX_OUTSTANDING = cordic_pkg::MAX_OUTSTANDING
) (
    input logic             clk,
    input logic             reset,
    cordic_arbiter_if.slave bus
);

    localparam int CW = cordic_pkg::CNT_WIDTH;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]      degree;
        logic [DATA_WIDTH-1:0]      x;
        logic [DATA_WIDTH-1:0]      y;
        logic [FLIP_FLAG_WIDTH-1:0] flip;
        logic                       arctan_en;
    } op_t;

    op_t         req_op [2];
    op_t         pipe_op;
    op_t         cdc_op_q;
    op_t         rsp_op_q;
    logic [1:0]  req_valid;
    logic [1:0]  eligible;
    logic [1:0]  ready;
    logic [1:0]  rsp_valid_q;
    logic        last_q;
    logic        cdc_valid_q;
    logic        err_q;
    logic [CW-1:0] cnt_q [2];
    cordic_tag_t tag_in;
    cordic_tag_t tag_tail;

    assign req_valid = {bus.r1_valid, bus.r0_valid};
    assign req_op[0] = '{degree: bus.r0_degree, x: bus.r0_x, y: bus.r0_y,
                         flip: bus.r0_flip, arctan_en: bus.r0_arctan_en};
    assign req_op[1] = '{degree: bus.r1_degree, x: bus.r1_x, y: bus.r1_y,
                         flip: bus.r1_flip, arctan_en: bus.r1_arctan_en};
    assign pipe_op   = '{degree: bus.cdc_degree_out, x: bus.cdc_x_out, y: bus.cdc_y_out,
                         flip: bus.cdc_flip_out, arctan_en: bus.cdc_arctan_en_out};

    // A response retiring this cycle frees its slot, so a full requester can
    // reissue in the same cycle and keep the pipeline saturated.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit -- no latches.
        eligible = '0;
        ready    = '0;
        for (int n = 0; n < 2; n++) begin
            eligible[n] = req_valid[n] & ((cnt_q[n] < MAX_CNT) | rsp_valid_q[n]);
        end
        if (!reset) begin
            unique case (eligible)
                2'b11:   ready = last_q ? 2'b01 : 2'b10;
                default: ready = eligible;
            endcase
        end
    end

    // ready is only raised for a valid requester, so it doubles as the grant.
    assign tag_in = '{valid: |ready, id: ready[1]};

    cordic_tag_line #(
        .DEPTH (PIPE_LATENCY + 1)
    ) u_tag_line (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_tail)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q      <= 1'b1;
            cdc_valid_q <= 1'b0;
            cdc_op_q    <= '0;
            rsp_valid_q <= '0;
            rsp_op_q    <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '{default: '0};
        end else begin
            cdc_valid_q <= |ready;
            if (|ready) begin
                last_q   <= ready[1];
                cdc_op_q <= req_op[ready[1]];
            end

            for (int n = 0; n < 2; n++) begin
                cnt_q[n] <= cnt_q[n] + CW'(ready[n]) - CW'(rsp_valid_q[n]);
            end

            // A tag/pipeline disagreement never produces a response.
            rsp_valid_q <= '0;
            if (tag_tail.valid && bus.cdc_valid_out) begin
                rsp_valid_q[tag_tail.id] <= 1'b1;
                rsp_op_q                 <= pipe_op;
            end
            if (tag_tail.valid != bus.cdc_valid_out) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.r0_ready         = ready[0];
    assign bus.r1_ready         = ready[1];
    assign bus.r0_rsp_valid     = rsp_valid_q[0];
    assign bus.r1_rsp_valid     = rsp_valid_q[1];
    assign bus.rsp_degree       = rsp_op_q.degree;
    assign bus.rsp_x            = rsp_op_q.x;
    assign bus.rsp_y            = rsp_op_q.y;
    assign bus.rsp_flip         = rsp_op_q.flip;
    assign bus.rsp_arctan_en    = rsp_op_q.arctan_en;
    assign bus.cdc_valid_in     = cdc_valid_q;
    assign bus.cdc_degree_in    = cdc_op_q.degree;
    assign bus.cdc_x_in         = cdc_op_q.x;
    assign bus.cdc_y_in         = cdc_op_q.y;
    assign bus.cdc_flip_in      = cdc_op_q.flip;
    assign bus.cdc_arctan_en_in = cdc_op_q.arctan_en;
    assign bus.err              = err_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: a behavioural fixed-latency pipeline that scrambles
// operands, per-cycle ready vectors and a response scoreboard.
module tb_cordic_arbiter;
    import cordic_pkg::*;

    localparam int L = PIPE_LATENCY;

    typedef struct packed {
        logic [15:0] degree;
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  flip;
        logic        arctan_en;
    } op_t;

    typedef struct {
        int   due;
        logic id;
        op_t  op;
    } exp_rsp_t;

    typedef struct {
        logic       v0;
        logic       v1;
        logic [1:0] rdy;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic inject = 1'b0;
    always #5 clk = ~clk;

    cordic_arbiter_if bus ();

    cordic_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int       n_cmp = 0;
    int       n_fail = 0;
    int       cyc = 0;
    exp_rsp_t sb[$];
    op_t      exp_cdc_op = '0;
    logic     exp_cdc_v = 1'b0;
    logic     exp_err = 1'b0;

    function automatic op_t xform(op_t o);
        op_t r;
        r.degree    = o.degree ^ 16'h5A5A;
        r.x         = o.x + 16'd3;
        r.y         = ~o.y;
        r.flip      = o.flip ^ 2'b01;
        r.arctan_en = ~o.arctan_en;
        return r;
    endfunction

    function automatic op_t gen_op(int k, int n);
        op_t g;
        g.degree    = 16'(k * 273) ^ (n != 0 ? 16'h8000 : 16'h0000);
        g.x         = 16'(k * 3 + n);
        g.y         = 16'(49152 - k * 7 - n);
        g.flip      = 2'(k + n);
        g.arctan_en = 1'(k + n);
        return g;
    endfunction

    function automatic op_t cdc_in_op();
        return '{degree: bus.cdc_degree_in, x: bus.cdc_x_in, y: bus.cdc_y_in,
                 flip: bus.cdc_flip_in, arctan_en: bus.cdc_arctan_en_in};
    endfunction

    function automatic op_t rsp_op();
        return '{degree: bus.rsp_degree, x: bus.rsp_x, y: bus.rsp_y,
                 flip: bus.rsp_flip, arctan_en: bus.rsp_arctan_en};
    endfunction

    // Behavioural CORDIC stand-in: L-cycle delay with a reversible scramble.
    logic pv [L];
    op_t  pd [L];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < L; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= bus.cdc_valid_in;
            pd[0] <= xform(cdc_in_op());
            for (int i = 1; i < L; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign bus.cdc_valid_out     = pv[L-1] | inject;
    assign bus.cdc_degree_out    = pd[L-1].degree;
    assign bus.cdc_x_out         = pd[L-1].x;
    assign bus.cdc_y_out         = pd[L-1].y;
    assign bus.cdc_flip_out      = pd[L-1].flip;
    assign bus.cdc_arctan_en_out = pd[L-1].arctan_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic v1, input op_t o0, input op_t o1);
        bus.r0_valid     = v0;
        bus.r0_degree    = o0.degree;
        bus.r0_x         = o0.x;
        bus.r0_y         = o0.y;
        bus.r0_flip      = o0.flip;
        bus.r0_arctan_en = o0.arctan_en;
        bus.r1_valid     = v1;
        bus.r1_degree    = o1.degree;
        bus.r1_x         = o1.x;
        bus.r1_y         = o1.y;
        bus.r1_flip      = o1.flip;
        bus.r1_arctan_en = o1.arctan_en;
    endtask

    // One clock: check registered outputs, apply inputs, check ready, record grants.
    task automatic step(input logic v0, input logic v1, input logic [1:0] exp_rdy,
                        input op_t o0, input op_t o1, input logic inj);
        logic [1:0] exp_rv;
        exp_rsp_t   e;
        @(posedge clk);
        cyc++;
        #1;
        exp_rv = 2'b00;
        if (sb.size() > 0 && sb[0].due == cyc) exp_rv[sb[0].id] = 1'b1;
        check("r0_rsp_valid", 64'(bus.r0_rsp_valid), 64'(exp_rv[0]));
        check("r1_rsp_valid", 64'(bus.r1_rsp_valid), 64'(exp_rv[1]));
        if (exp_rv != 2'b00) begin
            e = sb.pop_front();
            check("rsp_data", 64'(rsp_op()), 64'(e.op));
        end
        check("err", 64'(bus.err), 64'(exp_err));
        check("cdc_valid_in", 64'(bus.cdc_valid_in), 64'(exp_cdc_v));
        check("cdc_data", 64'(cdc_in_op()), 64'(exp_cdc_op));
        inject = inj;
        drive(v0, v1, o0, o1);
        #2;
        check("ready", 64'({bus.r1_ready, bus.r0_ready}), 64'(exp_rdy));
        exp_cdc_v = 1'b0;
        if (exp_rdy[0]) begin
            sb.push_back('{due: cyc + 2 + L, id: 1'b0, op: xform(o0)});
            exp_cdc_op = o0;
            exp_cdc_v  = 1'b1;
        end else if (exp_rdy[1]) begin
            sb.push_back('{due: cyc + 2 + L, id: 1'b1, op: xform(o1)});
            exp_cdc_op = o1;
            exp_cdc_v  = 1'b1;
        end
        if (inj) exp_err = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
    endtask

    // One reset edge; r0_valid may be held high to show ready stays low in reset.
    task automatic apply_reset(input logic hold_v0);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        inject = 1'b0;
        drive(hold_v0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        check("rst_ready", 64'({bus.r1_ready, bus.r0_ready}), 64'(0));
        check("rst_rsp_valid", 64'({bus.r1_rsp_valid, bus.r0_rsp_valid}), 64'(0));
        check("rst_cdc_valid_in", 64'(bus.cdc_valid_in), 64'(0));
        check("rst_err", 64'(bus.err), 64'(0));
        check("rst_cdc_data", 64'(cdc_in_op()), 64'(0));
        check("rst_rsp_data", 64'(rsp_op()), 64'(0));
        check("rst_cnt0", 64'(dut.cnt_q[0]), 64'(0));
        check("rst_cnt1", 64'(dut.cnt_q[1]), 64'(0));
        drive(1'b0, 1'b0, '0, '0);
        reset = 1'b0;
        sb.delete();
        exp_cdc_op = '0;
        exp_cdc_v  = 1'b0;
        exp_err    = 1'b0;
        cyc        = 0;
    endtask

    vec_t contention [8];
    vec_t credit [22];

    initial begin
        op_t op_a;

        for (int i = 0; i < 8; i++) begin
            contention[i] = '{v0: 1'b1, v1: 1'b1, rdy: (i % 2 == 0) ? 2'b01 : 2'b10};
        end
        for (int i = 0; i < 22; i++) begin
            credit[i] = '{v0: 1'b0, v1: 1'b1,
                          rdy: (i < 4 || (i >= 10 && i < 14) || i >= 20) ? 2'b10 : 2'b00};
        end
        op_a = '{degree: 16'hA600, x: 16'h0100, y: 16'h0402, flip: 2'b10, arctan_en: 1'b0};
        drive(1'b0, 1'b0, '0, '0);

        // Single op from r0 at cycle 5, response at cycle 5 + 2 + L.
        apply_reset(1'b0);
        idle(4);
        step(1'b1, 1'b0, 2'b01, op_a, '0, 1'b0);
        idle(L + 3);
        check("single_cnt0", 64'(dut.cnt_q[0]), 64'(0));
        check("single_drained", 64'(sb.size()), 64'(0));

        // Both requesters continuously valid: strict alternation from r0.
        apply_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            step(contention[i].v0, contention[i].v1, contention[i].rdy,
                 gen_op(i, 0), gen_op(i, 1), 1'b0);
        end
        idle(L + 4);
        check("contention_drained", 64'(sb.size()), 64'(0));

        // r1 alone runs into its credit limit and refills on each response.
        apply_reset(1'b0);
        for (int i = 0; i < 14; i++) begin
            step(credit[i].v0, credit[i].v1, credit[i].rdy, '0, gen_op(i, 1), 1'b0);
        end
        check("credit_cnt1_full", 64'(dut.cnt_q[1]), 64'(MAX_OUTSTANDING));
        for (int i = 14; i < 22; i++) begin
            step(credit[i].v0, credit[i].v1, credit[i].rdy, '0, gen_op(i, 1), 1'b0);
        end
        idle(L + 6);
        check("credit_cnt1_empty", 64'(dut.cnt_q[1]), 64'(0));
        check("credit_drained", 64'(sb.size()), 64'(0));

        // Spurious pipeline valid with an empty tag tail: sticky err, no response.
        apply_reset(1'b0);
        idle(2);
        step(1'b0, 1'b0, 2'b00, '0, '0, 1'b1);
        idle(5);
        apply_reset(1'b0);

        // Reset with three ops in flight, then a fresh contention won by r0.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b01, gen_op(i + 40, 0), '0, 1'b0);
        idle(2);
        apply_reset(1'b1);
        step(1'b1, 1'b1, 2'b01, gen_op(50, 0), gen_op(50, 1), 1'b0);
        idle(L + 4);
        check("midflight_cnt0", 64'(dut.cnt_q[0]), 64'(0));
        check("midflight_drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
